// File: rtl/dmem_pkg.sv
// dmem_pkg: MemOp encodings, arbiter FSM state and access-size decode shared by CPU, memory and arbiter
package dmem_pkg;
  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_B  = 3'b001,
    OP_H  = 3'b010,
    OP_BU = 3'b101,
    OP_HU = 3'b110
  } memOp_t;
  typedef enum logic {IDLE, ACCESS} state_t;
  // Bytes touched by an op; 0 marks an undefined encoding.
  function automatic logic [2:0] opSize(input logic [2:0] op);
    return op == OP_W ? 3'd4 :
           (op == OP_B || op == OP_BU) ? 3'd1 :
           (op == OP_H || op == OP_HU) ? 3'd2 : 3'd0;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; lastGnt=1 means p1 won last, so p0 wins a tie
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastGnt,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | lastGnt);
  assign gnt[1] = req[1] & (~req[0] | ~lastGnt);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data memory arbiter, one transaction per two cycles
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [2:0]  p0_op,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [2:0]  p1_op,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_en,
  output logic        mem_wren,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);
  state_t      state;
  logic        lastGnt, owner, cmdWe, respErr, illegal, access;
  logic [2:0]  cmdOp, size;
  logic [31:0] cmdAddr, cmdWdata, respData;
  logic [32:0] lastByte;
  logic [1:0]  arbGnt, gnt, rvalid;
  rr_arb2 u_arb (.req({p1_req, p0_req}), .lastGnt(lastGnt), .gnt(arbGnt));
  assign gnt = (rst_n && state == IDLE) ? arbGnt : 2'b00;
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];
  // Legality is judged on the latched command; 33 bits keep the range check wrap-free.
  assign size = opSize(cmdOp);
  assign lastByte = {1'b0, cmdAddr} + {30'd0, size} - 33'd1;
  assign illegal = size == 3'd0 || (cmdWe && cmdOp[2]) || lastByte >= 33'(MEM_BYTES);
  assign access = state == ACCESS;
  assign mem_en = rst_n & access & ~illegal;
  assign mem_wren = mem_en & cmdWe;
  assign mem_op = access ? cmdOp : 3'd0;
  assign mem_addr = access ? cmdAddr : 32'd0;
  assign mem_din = access ? cmdWdata : 32'd0;
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata = rvalid[0] ? respData : 32'd0;
  assign p1_rdata = rvalid[1] ? respData : 32'd0;
  assign p0_err = rvalid[0] & respErr;
  assign p1_err = rvalid[1] & respErr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      lastGnt <= 1'b1;
      owner <= 1'b0;
      cmdWe <= 1'b0;
      cmdOp <= 3'd0;
      cmdAddr <= 32'd0;
      cmdWdata <= 32'd0;
      rvalid <= 2'b00;
      respData <= 32'd0;
      respErr <= 1'b0;
    end else begin
      rvalid <= 2'b00;
      if (state == IDLE) begin
        if (|gnt) begin
          owner <= gnt[1];
          lastGnt <= gnt[1];
          cmdWe <= gnt[1] ? p1_we : p0_we;
          cmdOp <= gnt[1] ? p1_op : p0_op;
          cmdAddr <= gnt[1] ? p1_addr : p0_addr;
          cmdWdata <= gnt[1] ? p1_wdata : p0_wdata;
          state <= ACCESS;
        end
      end else begin
        rvalid <= owner ? 2'b10 : 2'b01;
        respData <= (illegal || cmdWe) ? 32'd0 : mem_dout;
        respErr <= illegal;
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, data memory size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- p0_req / p1_req  input  1  requester transaction request.
- p0_we / p1_we  input  1  1 = store, 0 = load.
- p0_op / p1_op  input  3  MemOp encoding: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned.
- p0_addr / p1_addr  input  32  byte address.
- p0_wdata / p1_wdata  input  32  store data.
- p0_gnt / p1_gnt  output  1  request accepted this cycle.
- p0_rvalid / p1_rvalid  output  1  one-cycle response strobe.
- p0_rdata / p1_rdata  output  32  load data, valid with rvalid.
- p0_err / p1_err  output  1  error flag, valid with rvalid.
- mem_en, mem_wren  output  1  memory enable and write enable.
- mem_op  output  3  MemOp to memory.
- mem_addr, mem_din  output  32  memory address and store data.
- mem_dout  input  32  combinational memory read data.

Function
REQ-003 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-004 In IDLE with at least one req high, SHALL assert exactly one gnt combinationally, latch that port's we/op/addr/wdata and its port id at the clock edge, then enter ACCESS.
REQ-005 Arbitration SHALL be round-robin: a sole requester wins; when both request, the port not granted last wins; the last-grant pointer updates only on a grant.
REQ-006 No gnt SHALL be asserted in ACCESS; requesters hold req and payload until gnt.
REQ-007 In ACCESS, SHALL drive mem_en=1, mem_wren=latched we, mem_op/mem_addr/mem_din from the latched command; in IDLE all mem_* outputs SHALL be 0.
REQ-008 A store SHALL commit at the clock edge ending ACCESS; a load SHALL capture mem_dout at that edge.
REQ-009 The cycle after ACCESS, SHALL assert rvalid for the owning port only, for one cycle; rdata = captured load data (0 for stores), err = 0.
REQ-010 Latency SHALL be fixed: gnt in cycle N, memory access in N+1, rvalid in N+2; a new grant may occur in N+2, giving one transaction per 2 cycles.
REQ-011 A command SHALL be illegal when op is in {011,100,111}, or when we=1 and op is in {101,110}, or when addr+size-1 >= MEM_BYTES (size 4/2/1 per op).
REQ-012 An illegal command SHALL still take the ACCESS cycle, but with mem_en=0 and mem_wren=0, followed by rvalid with err=1 and rdata=0.
REQ-013 Misaligned legal accesses SHALL be forwarded unchanged; alignment is not checked.
REQ-014 Simultaneous req on both ports when the pointer is at reset value SHALL grant p0.

Reset
REQ-015 With rst_n low at a posedge, SHALL set: state=IDLE, last-grant pointer=p1 (so p0 wins the first tie), all rvalid/err=0, rdata=0, latched command=0.
REQ-016 mem_en and mem_wren SHALL be gated by rst_n combinationally, so no store commits in a cycle with rst_n low, even mid-ACCESS; an in-flight transaction is dropped with no rvalid.
REQ-017 gnt SHALL be 0 while rst_n is low.

Structure
REQ-018 MemOp encodings, the FSM state type and the access-size decode SHALL live in shared package dmem_pkg, also usable by the CPU and memory.
REQ-019 Round-robin selection SHALL be sub-module rr_arb2 (inputs req[1:0] and pointer; output one-hot grant); everything else stays flat.

Verification
REQ-020 p0 load op=000 addr=0x10, memory holds 0x11223344 there -> p0_gnt in N, mem_en in N+1, p0_rvalid in N+2 with rdata=0x11223344, err=0.
REQ-021 Both ports req every cycle -> grants alternate p0,p1,p0,p1, one grant every 2 cycles.
REQ-022 p1 store op=001 addr=5 wdata=0xAB, then p1 load op=101 addr=5 -> rdata=0x000000AB; then load op=001 -> rdata=0xFFFFFFAB.
REQ-023 p0 store op=110 or op=011, or load op=000 addr=4094 with MEM_BYTES=4096 -> mem_en stays 0, p0_rvalid with err=1, rdata=0, memory unchanged.
REQ-024 rst_n low during ACCESS of a store addr=0 -> memory byte 0 unchanged, no rvalid, FSM IDLE, next tied request granted to p0.
